// File: rtl/gen_gamma_decoder.sv
// Gamma decoder: subtracts queued noise keys from mixed words (od = md - nk).
// The key FIFO feeds a one-entry registered valid/ready output stage.
module gen_gamma_decoder #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [SIZE-1:0]            nk,
  input  logic                       nk_push,
  output logic                       key_full,
  output logic [$clog2(DEPTH+1)-1:0] key_cnt,
  output logic                       key_ovf,
  input  logic [SIZE:0]              md,
  input  logic                       md_valid,
  output logic                       md_ready,
  output logic [SIZE-1:0]            od,
  output logic                       od_err,
  output logic                       od_valid,
  input  logic                       od_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovf;
  state_e          state;

  logic            accept;
  logic            push_ok;
  logic [SIZE:0]   diff;

  assign key_cnt  = cnt;
  assign key_full = (cnt == FullCnt);
  assign key_ovf  = ovf;
  assign od_valid = (state == StFull);

  // Ready depends only on registered state and od_ready, never on md_valid.
  assign md_ready = (cnt != '0) && ((state == StEmpty) || od_ready);
  assign accept   = md_valid && md_ready;
  assign push_ok  = nk_push && ((cnt != FullCnt) || accept);
  assign diff     = md - {1'b0, mem[rd_ptr]};

  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[wr_ptr] <= nk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (accept) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (nk_push && !push_ok) begin
        ovf <= 1'b1;
      end
      if (push_ok && !accept) begin
        cnt <= cnt + CW'(1);
      end else if (!push_ok && accept) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StEmpty;
      od     <= '0;
      od_err <= 1'b0;
    end else if (clr) begin
      state <= StEmpty;
    end else begin
      unique case (state)
        StEmpty: begin
          if (accept) begin
            state  <= StFull;
            od     <= diff[SIZE-1:0];
            od_err <= diff[SIZE];
          end
        end
        StFull: begin
          if (accept) begin
            od     <= diff[SIZE-1:0];
            od_err <= diff[SIZE];
          end else if (od_ready) begin
            state <= StEmpty;
          end
        end
        default: state <= StEmpty;
      endcase
    end
  end

endmodule
